pwm_capture: RTL and testbench

- Receive-side counterpart of the team's PWM generator.
- Samples an incoming PWM waveform and measures its period and high time in clk cycles.
- Publishes one measurement per PWM cycle with a valid strobe, and flags a stuck line.
- Used for loopback self-test of the generator and for reading external PWM sources on the Basys3.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_sync_edge.sv | 41 ++++
 rtl/pwm_capture.sv | 156 +++++++++++++++
 tb/tb_pwm_capture.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Definitions shared by the PWM generator and the PWM capture block.
package pwm_pkg;

  // Counter width shared with the generator's OCRA/DC registers.
  localparam int PWM_CNT_W = 32;

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, plus registered rise/fall strobes.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   s_sync;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Strobes are registered so they land SYNC_STAGES+1 cycles after the input
  // transition; s_o is the edge-detect flop, aligned with the strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      s_d_q  <= s_sync;
      rise_q <= s_sync & ~s_d_q;
      fall_q <= ~s_sync & s_d_q;
    end
  end

  assign s_o    = s_d_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM waveform in clk cycles,
// publishing one result per PWM cycle and flagging a line stuck high or low.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int          CNT_W       = PWM_CNT_W,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ARM_CNT   = CNT_W'(SYNC_STAGES + 3);

  logic s, rise, fall;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (pwm_in),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_lat_q, high_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             stuck_hi_q, stuck_hi_d;
  logic             stuck_lo_q, stuck_lo_d;
  logic             armed_q, armed_d;
  logic             timeout;

  assign timeout = (cnt_q == TIMEOUT_C);

  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (!timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The synchronizer flushes from 0 after reset, so a line already high at
  // release shows up as a false rise. Acquisition is held off until the line
  // has been seen low once the pipeline has filled.
  always_comb begin
    state_d     = state_q;
    high_lat_d  = high_lat_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    stuck_hi_d  = stuck_hi_q;
    stuck_lo_d  = stuck_lo_q;
    armed_d     = armed_q | (~s & (cnt_q >= ARM_CNT));

    if (rise) begin
      stuck_hi_d = 1'b0;
      stuck_lo_d = 1'b0;
    end

    case (state_q)
      ACQ: begin
        if (rise && armed_q) begin
          state_d = HIGH;
        end else if (!rise && timeout && !s && !stuck_hi_q) begin
          stuck_lo_d = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          high_lat_d = cnt_q;
          state_d    = LOW;
        end else if (timeout) begin
          state_d     = ACQ;
          stuck_hi_d  = 1'b1;
          stuck_lo_d  = 1'b0;
          locked_d    = 1'b0;
          valid_d     = 1'b1;
          period_d    = '0;
          high_time_d = '0;
        end
      end
      LOW: begin
        // A rise on the timeout cycle still closes the period normally.
        if (rise) begin
          period_d    = cnt_q;
          high_time_d = high_lat_q;
          valid_d     = 1'b1;
          locked_d    = 1'b1;
          state_d     = HIGH;
        end else if (timeout) begin
          state_d     = ACQ;
          stuck_lo_d  = 1'b1;
          stuck_hi_d  = 1'b0;
          locked_d    = 1'b0;
          valid_d     = 1'b1;
          period_d    = '0;
          high_time_d = '0;
        end
      end
      default: state_d = ACQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACQ;
      cnt_q       <= '0;
      high_lat_q  <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      stuck_hi_q  <= 1'b0;
      stuck_lo_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_lat_q  <= high_lat_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      stuck_hi_q  <= stuck_hi_d;
      stuck_lo_q  <= stuck_lo_d;
      armed_q     <= armed_d;
    end
  end

  // valid is a one-cycle strobe with no back-pressure: period/high_time are
  // new on the valid cycle and hold until the next strobe.
  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign stuck_hi  = stuck_hi_q;
  assign stuck_lo  = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a behavioural PWM source feeds the DUT and
// each scenario task checks strobes, flags and latency against hand-derived values.
module tb_pwm_capture;

  localparam int CNT_W   = 32;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 1000;
  localparam int LAT     = SYNC + 2;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             valid, locked, stuck_hi, stuck_lo;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  // PWM source: new period/high settings take effect at the start of a period.
  int gen_p = 100, gen_h = 0, nxt_p = 100, nxt_h = 0, phase = 0, rises = 0;
  logic [31:0] exp_q[$];

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .stuck_hi  (stuck_hi),
    .stuck_lo  (stuck_lo)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- PWM driver ----------------
  initial begin
    logic lvl;
    forever begin
      @(posedge clk);
      #1;
      if (phase == 0) begin
        gen_p = nxt_p;
        gen_h = nxt_h;
      end
      lvl = (phase < gen_h);
      if (lvl && !pwm_in) begin
        exp_q.push_back(cyc);
        rises++;
      end
      pwm_in = lvl;
      phase = (phase + 1 >= gen_p) ? 0 : phase + 1;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({period, high_time, valid, locked, stuck_hi, stuck_lo} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: p=%0d h=%0d v=%b l=%b sh=%b sl=%b, expected all 0",
               period, high_time, valid, locked, stuck_hi, stuck_lo);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({period, high_time, valid, locked, stuck_hi, stuck_lo} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: p=%0d h=%0d v=%b l=%b sh=%b sl=%b, expected all 0",
               period, high_time, valid, locked, stuck_hi, stuck_lo);
    end
  endtask

  task automatic test_basic();
    int n;
    n = 0;
    nxt_p = 100;
    nxt_h = 25;
    exp_q.delete();
    repeat (700) begin
      @(negedge clk);
      if (valid) begin
        n++;
        while (exp_q.size() > 0 && exp_q[0] < cyc - LAT) void'(exp_q.pop_front());
        checks++;
        if (exp_q.size() == 0 || exp_q[0] != cyc - LAT) begin
          failures++;
          $display("FAIL basic_latency: valid at cycle %0d, oldest pending rise %0d, required rise at %0d",
                   cyc, (exp_q.size() > 0) ? exp_q[0] : 0, cyc - LAT);
        end
        if (n >= 2) begin
          checks++;
          if (period !== 100 || high_time !== 25 || locked !== 1'b1) begin
            failures++;
            $display("FAIL basic_100_25: strobe %0d p=%0d h=%0d l=%b, required 100/25 l=1",
                     n, period, high_time, locked);
          end
        end
      end
    end
    checks++;
    if (n < 5) begin
      failures++;
      $display("FAIL basic_count: %0d strobes, required at least 5", n);
    end
  endtask

  task automatic test_duty_change();
    int n;
    bit dropped;
    n = 0;
    dropped = 1'b0;
    nxt_h = 50;
    repeat (600) begin
      @(negedge clk);
      if (locked !== 1'b1) dropped = 1'b1;
      if (valid) begin
        n++;
        if (n >= 2) begin
          checks++;
          if (period !== 100 || high_time !== 50) begin
            failures++;
            $display("FAIL duty_100_50: strobe %0d p=%0d h=%0d, required 100/50", n, period, high_time);
          end
        end
      end
    end
    checks++;
    if (dropped) begin
      failures++;
      $display("FAIL duty_locked: locked dropped to 0 during duty change, required steady 1");
    end
    checks++;
    if (n < 4) begin
      failures++;
      $display("FAIL duty_count: %0d strobes, required at least 4", n);
    end
  endtask

  task automatic test_stuck_hi();
    bit seen, cleared;
    int n;
    int r0;
    int unsigned last_rise;
    seen = 1'b0;
    cleared = 1'b0;
    n = 0;
    nxt_h = 100;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(negedge clk);
      if (stuck_hi) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stuck_hi_wait: stuck_hi=0 after 1500 cycles of constant high, required 1");
    end else begin
      checks++;
      if (valid !== 1'b1 || period !== 0 || high_time !== 0 || locked !== 1'b0 || stuck_lo !== 1'b0) begin
        failures++;
        $display("FAIL stuck_hi_outputs: v=%b p=%0d h=%0d l=%b sl=%b, required v=1 p=0 h=0 l=0 sl=0",
                 valid, period, high_time, locked, stuck_lo);
      end
      last_rise = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : 0;
      checks++;
      if (cyc - last_rise != TIMEOUT + LAT) begin
        failures++;
        $display("FAIL stuck_hi_delay: flagged %0d cycles after last rise, required %0d",
                 cyc - last_rise, TIMEOUT + LAT);
      end
    end
    r0 = rises;
    nxt_h = 50;
    for (int i = 0; i < 500 && n == 0; i++) begin
      @(negedge clk);
      if (!cleared && !stuck_hi) begin
        cleared = 1'b1;
        checks++;
        if (rises - r0 != 1) begin
          failures++;
          $display("FAIL stuck_hi_clear: cleared after %0d rises, required 1", rises - r0);
        end
      end
      if (valid) begin
        n = 1;
        checks++;
        if (stuck_hi !== 1'b0 || period !== 100 || high_time !== 50 || locked !== 1'b1) begin
          failures++;
          $display("FAIL stuck_hi_recover: sh=%b p=%0d h=%0d l=%b, required sh=0 100/50 l=1",
                   stuck_hi, period, high_time, locked);
        end
      end
    end
    checks++;
    if (n == 0) begin
      failures++;
      $display("FAIL stuck_hi_recover_wait: no strobe within 500 cycles of restoring 100/50");
    end
  endtask

  task automatic test_stuck_lo();
    int first, nv;
    first = 0;
    nv = 0;
    nxt_h = 0;
    repeat (110) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (valid) nv++;
      if (stuck_lo && first == 0) first = i;
    end
    checks++;
    if (first != TIMEOUT + 1) begin
      failures++;
      $display("FAIL stuck_lo_delay: stuck_lo first seen %0d cycles after reset release, required %0d",
               first, TIMEOUT + 1);
    end
    checks++;
    if (nv != 0) begin
      failures++;
      $display("FAIL stuck_lo_valid: %0d strobes on a constant-low line, required 0", nv);
    end
    checks++;
    if (period !== 0 || high_time !== 0 || locked !== 1'b0 || stuck_hi !== 1'b0 || stuck_lo !== 1'b1) begin
      failures++;
      $display("FAIL stuck_lo_outputs: p=%0d h=%0d l=%b sh=%b sl=%b, required p=0 h=0 l=0 sh=0 sl=1",
               period, high_time, locked, stuck_hi, stuck_lo);
    end
  endtask

  task automatic test_min_wave();
    int n;
    n = 0;
    nxt_p = 2;
    nxt_h = 1;
    exp_q.delete();
    repeat (400) begin
      @(negedge clk);
      if (valid) begin
        n++;
        checks++;
        if (period !== 2 || high_time !== 1 || locked !== 1'b1) begin
          failures++;
          $display("FAIL min_2_1: strobe %0d p=%0d h=%0d l=%b, required 2/1 l=1", n, period, high_time, locked);
        end
        while (exp_q.size() > 0 && exp_q[0] < cyc - LAT) void'(exp_q.pop_front());
        checks++;
        if (exp_q.size() == 0 || exp_q[0] != cyc - LAT) begin
          failures++;
          $display("FAIL min_latency: valid at cycle %0d, oldest pending rise %0d, required rise at %0d",
                   cyc, (exp_q.size() > 0) ? exp_q[0] : 0, cyc - LAT);
        end
      end
    end
    checks++;
    if (n < 100 || stuck_lo !== 1'b0) begin
      failures++;
      $display("FAIL min_count: %0d strobes sl=%b, required at least 100 strobes and sl=0", n, stuck_lo);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int n, r0;
    found = 1'b0;
    n = 0;
    nxt_p = 100;
    nxt_h = 25;
    repeat (400) @(negedge clk);
    checks++;
    if (locked !== 1'b1 || period !== 100 || high_time !== 25) begin
      failures++;
      $display("FAIL pre_reset_lock: p=%0d h=%0d l=%b, required 100/25 l=1", period, high_time, locked);
    end
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (gen_p == 100 && gen_h == 25 && phase == 10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid_align: never reached mid-high of a 100/25 period");
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({period, high_time, valid, locked, stuck_hi, stuck_lo} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: p=%0d h=%0d v=%b l=%b sh=%b sl=%b, expected all 0",
               period, high_time, valid, locked, stuck_hi, stuck_lo);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r0 = rises;
    for (int i = 0; i < 400 && n == 0; i++) begin
      @(negedge clk);
      if (valid) begin
        n = 1;
        checks++;
        if (rises - r0 != 2 || period !== 100 || high_time !== 25 || locked !== 1'b1) begin
          failures++;
          $display("FAIL reset_mid_first: after %0d rises p=%0d h=%0d l=%b, required 2 rises 100/25 l=1",
                   rises - r0, period, high_time, locked);
        end
      end
    end
    checks++;
    if (n == 0) begin
      failures++;
      $display("FAIL reset_mid_wait: no strobe within 400 cycles after reset release");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_duty_change();
    test_stuck_hi();
    test_stuck_lo();
    test_min_wave();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
